// File: rtl/data_mem_unit.sv
// data_mem_unit: fixed-latency req/ready data memory with byte/half/word access and load extension
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        Mem_Write,
  input  logic [1:0]  Memory_Byte,
  input  logic        Mem_Sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic                  r_we, r_sgn;
  logic [1:0]            r_sz;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_mis;
  logic [3:0]            w_be;
  logic [31:0]           w_wd, w_word, w_ld;
  logic [15:0]           w_h;
  logic [7:0]            w_b;
  logic                  w_unused;
  assign w_unused = ^addr[31:ADDR_WIDTH+2];
  assign ready = r_state == DONE;
  assign busy  = r_state != IDLE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state: request taken only in IDLE, BUSY and DONE last one cycle each
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req ? BUSY : IDLE;
      BUSY:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // access decode from latched request fields
  always_comb begin
    w_idx  = r_addr[ADDR_WIDTH+1:2];
    w_mis  = (r_sz == 2'b01) | (r_sz == 2'b00 & |r_addr[1:0]) | (r_sz == 2'b10 & r_addr[0]);
    w_be   = r_sz == 2'b00 ? 4'hF : r_sz == 2'b10 ? (r_addr[1] ? 4'hC : 4'h3) : 4'b0001 << r_addr[1:0];
    w_wd   = r_sz == 2'b00 ? r_wdata : r_sz == 2'b10 ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
    w_word = r_mem[w_idx];
    w_b    = w_word[{r_addr[1:0], 3'b000} +: 8];
    w_h    = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_ld   = r_sz == 2'b00 ? w_word : r_sz == 2'b10 ? {{16{r_sgn & w_h[15]}}, w_h} : {{24{r_sgn & w_b[7]}}, w_b};
  end
  // latch request in IDLE, register load result and error flag on the BUSY edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we     <= 1'b0;
      r_sgn    <= 1'b0;
      r_sz     <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      rdata    <= '0;
      misalign <= 1'b0;
    end else if (r_state == IDLE && req) begin
      r_we    <= Mem_Write;
      r_sgn   <= Mem_Sign;
      r_sz    <= Memory_Byte;
      r_addr  <= addr[ADDR_WIDTH+1:0];
      r_wdata <= wdata;
    end else if (r_state == BUSY) begin
      rdata    <= (w_mis | r_we) ? 32'h0 : w_ld;
      misalign <= w_mis;
    end
  // lane-masked store on the BUSY edge; array is never reset
  always_ff @(posedge clk)
    if (r_state == BUSY && r_we && !w_mis)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed self-checking bench for data_mem_unit
module tb_data_mem_unit;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, Mem_Write = 1'b0, Mem_Sign = 1'b0;
  logic [1:0]  Memory_Byte = 2'b00;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        ready, misalign, busy;
  int          checks = 0, errors = 0;
  logic [31:0] g_rd;
  logic        g_mis;
  int          pulses;

  data_mem_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .req(req), .Mem_Write(Mem_Write), .Memory_Byte(Memory_Byte),
    .Mem_Sign(Mem_Sign), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one access starting at a negedge in IDLE; returns at a negedge in IDLE
  task automatic acc(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req = 1'b1; Mem_Write = we; Memory_Byte = sz; Mem_Sign = sg; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
    do begin @(negedge clk); n++; end while (!ready && n < 10);
    chk("latency", 32'(n), 32'd2);
    g_rd = rdata; g_mis = misalign;
    @(negedge clk);
    chk("ready_drop", {31'b0, ready}, 32'd0);
    chk("rdata_hold", rdata, g_rd);
  endtask

  initial begin
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {29'b0, ready, misalign, busy}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    acc(1, 2'b00, 0, 32'h10, 32'hDEADBEEF);
    chk("sw_rdata", g_rd, 32'h0);
    chk("sw_mis", {31'b0, g_mis}, 32'd0);
    acc(0, 2'b00, 0, 32'h10, 0);
    chk("lw_10", g_rd, 32'hDEADBEEF);
    chk("lw_10_mis", {31'b0, g_mis}, 32'd0);

    acc(1, 2'b00, 0, 32'h20, 32'h80FF7F01);
    acc(0, 2'b11, 1, 32'h23, 0); chk("lb_23", g_rd, 32'hFFFFFF80);
    acc(0, 2'b11, 0, 32'h23, 0); chk("lbu_23", g_rd, 32'h00000080);
    acc(0, 2'b11, 1, 32'h20, 0); chk("lb_20", g_rd, 32'h00000001);
    acc(0, 2'b11, 1, 32'h21, 0); chk("lb_21", g_rd, 32'h0000007F);
    acc(0, 2'b10, 0, 32'h22, 0); chk("lhu_22", g_rd, 32'h000080FF);
    acc(0, 2'b10, 1, 32'h22, 0); chk("lh_22", g_rd, 32'hFFFF80FF);
    acc(0, 2'b10, 1, 32'h20, 0); chk("lh_20", g_rd, 32'h00007F01);
    acc(0, 2'b00, 1, 32'h20, 0); chk("lw_sign_ignored", g_rd, 32'h80FF7F01);

    acc(1, 2'b00, 0, 32'h30, 32'h11223344);
    acc(1, 2'b11, 0, 32'h31, 32'h000000AA);
    acc(1, 2'b10, 0, 32'h32, 32'h0000BEEF);
    acc(0, 2'b00, 0, 32'h30, 0); chk("partial_30", g_rd, 32'hBEEFAA44);

    acc(1, 2'b00, 0, 32'h40, 32'h01020304);
    acc(1, 2'b00, 0, 32'h41, 32'hFFFFFFFF);
    chk("sw_41_mis", {31'b0, g_mis}, 32'd1);
    chk("sw_41_rdata", g_rd, 32'h0);
    acc(0, 2'b00, 0, 32'h40, 0); chk("w40_unchanged", g_rd, 32'h01020304);
    acc(0, 2'b10, 1, 32'h43, 0);
    chk("lh_43_mis", {31'b0, g_mis}, 32'd1);
    chk("lh_43_rdata", g_rd, 32'h0);
    acc(0, 2'b01, 0, 32'h40, 0); chk("sz01_mis", {31'b0, g_mis}, 32'd1);
    acc(1, 2'b11, 0, 32'h43, 32'h00000077); chk("sb_43_mis", {31'b0, g_mis}, 32'd0);
    acc(0, 2'b00, 0, 32'h40, 0); chk("w40_after_sb", g_rd, 32'h77020304);

    // req held high: new access every 3 cycles, nothing starts in BUSY/DONE
    pulses = 0;
    req = 1'b1; Mem_Write = 1'b0; Memory_Byte = 2'b00; Mem_Sign = 1'b0; addr = 32'h10;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("held_ready", {31'b0, ready}, {31'b0, (i % 3) == 2});
      chk("held_busy", {31'b0, busy}, {31'b0, (i % 3) != 0});
      if (ready) begin pulses++; chk("held_rdata", rdata, 32'hDEADBEEF); end
    end
    req = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd3);
    @(negedge clk);

    acc(1, 2'b00, 0, 32'h1000, 32'hA5A5C3C3);
    acc(0, 2'b00, 0, 32'h0000, 0); chk("wrap", g_rd, 32'hA5A5C3C3);

    acc(1, 2'b00, 0, 32'h50, 32'hCAFEF00D);
    acc(0, 2'b00, 0, 32'h50, 0); chk("lw_50_pre", g_rd, 32'hCAFEF00D);
    req = 1'b1; Mem_Write = 1'b1; Memory_Byte = 2'b00; addr = 32'h50; wdata = 32'h12345678;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_flags", {29'b0, ready, misalign, busy}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    acc(0, 2'b00, 0, 32'h50, 0); chk("lw_50_post", g_rd, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
